// File: rtl/tx_sched_pkg.sv
// Shared types and defaults for the backscatter reply scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tx_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_T1  = 3'd1,
    ST_PREAMBLE = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam int          T1_CYC_DEF   = 10;
  localparam int          WDOG_MAX_DEF = 50000;
  // T1 turnaround counter width; covers the full 1..255 range.
  localparam int          T1_W         = 8;
  localparam logic [1:0]  M_FM0        = 2'b00;

endpackage

// File: rtl/tx_wdog.sv
// Loadable up/down counter with a terminal-count flag (T1 countdown, watchdog).
// Latency: load/step take effect at the next clk edge; o_tc is combinational on the count.
// Backpressure: none; the count holds at the terminal value instead of wrapping.
module tx_wdog #(
  parameter int             W  = 16,
  parameter bit             UP = 1'b1,
  parameter logic [W-1:0]   TC = '0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [W-1:0]  i_load_val,
  input  logic          i_en,
  output logic          o_tc
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_cnt;

  // Counter register: load wins over stepping; stepping stops at the terminal value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && !o_tc) begin
      r_cnt <= UP ? (r_cnt + ONE) : (r_cnt - ONE);
    end
  end

  assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/tx_sched.sv
// Reply scheduler: T1 turnaround, then gates frame/encoder clocks until frame done, abort or watchdog.
// Latency: start_working rises T1_CYC edges after the edge that accepts reply_req; outputs are registered.
// Backpressure: reply_req outside IDLE is dropped (not queued); abort overrides everything.
module tx_sched
  import tx_sched_pkg::*;
#(
  parameter int T1_CYC   = T1_CYC_DEF,
  parameter int WDOG_W   = 16,
  parameter int WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic        i_clk_blf,
  input  logic        i_rst_for_new_package,
  input  logic        i_reply_req,
  input  logic        i_abort,
  input  logic [1:0]  i_m,
  input  logic        i_trext,
  input  logic        i_p_complete,
  input  logic        i_bs_complete,
  output logic        o_start_working,
  output logic        o_en_frm_clk,
  output logic        o_en_fm0_clk,
  output logic        o_en_mil_clk,
  output logic        o_tx_busy,
  output logic        o_tx_done,
  output logic        o_tx_err,
  // Latched pilot-tone select; the frame generator times the pilot, this is status only.
  output logic        o_trext_q
);

  state_t       r_state;
  state_t       w_nxt;
  logic [1:0]   r_m_q;
  logic         r_trext_q;
  logic         r_start_working;
  logic         r_en_frm_clk;
  logic         r_en_fm0_clk;
  logic         r_en_mil_clk;
  logic         r_tx_busy;
  logic         r_tx_done;
  logic         r_tx_err;

  logic         w_accept;
  logic         w_err_set;
  logic         w_nxt_active;
  logic         w_t1_tc;
  logic         w_wd_tc;
  logic         w_in_wait;
  logic         w_in_active;

  assign w_accept     = (r_state == ST_IDLE) && i_reply_req && !i_abort;
  assign w_in_wait    = (r_state == ST_WAIT_T1);
  assign w_in_active  = (r_state == ST_PREAMBLE) || (r_state == ST_PAYLOAD);
  assign w_nxt_active = (w_nxt == ST_PREAMBLE) || (w_nxt == ST_PAYLOAD);

  // T1 countdown: loaded with T1_CYC-1 on accept, reaches 0 on the last WAIT_T1 cycle.
  tx_wdog #(
    .W  (T1_W),
    .UP (1'b0),
    .TC ('0)
  ) u_t1_cnt (
    .i_clk      (i_clk_blf),
    .i_rst      (i_rst_for_new_package),
    .i_load     (w_accept),
    .i_load_val (T1_W'(T1_CYC - 1)),
    .i_en       (w_in_wait),
    .o_tc       (w_t1_tc)
  );

  // Watchdog: cleared when leaving WAIT_T1, counts every PREAMBLE/PAYLOAD cycle.
  tx_wdog #(
    .W  (WDOG_W),
    .UP (1'b1),
    .TC (WDOG_W'(WDOG_MAX - 1))
  ) u_wd_cnt (
    .i_clk      (i_clk_blf),
    .i_rst      (i_rst_for_new_package),
    .i_load     (w_in_wait && w_t1_tc),
    .i_load_val ('0),
    .i_en       (w_in_active),
    .o_tc       (w_wd_tc)
  );

  // State register.
  always_ff @(posedge i_clk_blf or posedge i_rst_for_new_package) begin
    if (i_rst_for_new_package) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Next state: abort first, then frame completion, then watchdog expiry, then preamble done.
  always_comb begin
    w_nxt     = r_state;
    w_err_set = 1'b0;
    if (i_abort) begin
      w_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_reply_req) w_nxt = ST_WAIT_T1;
        end
        ST_WAIT_T1: begin
          if (w_t1_tc) w_nxt = ST_PREAMBLE;
        end
        ST_PREAMBLE: begin
          if (i_bs_complete) begin
            w_nxt = ST_DONE;
          end else if (w_wd_tc) begin
            w_nxt     = ST_IDLE;
            w_err_set = 1'b1;
          end else if (i_p_complete) begin
            w_nxt = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (i_bs_complete) begin
            w_nxt = ST_DONE;
          end else if (w_wd_tc) begin
            w_nxt     = ST_IDLE;
            w_err_set = 1'b1;
          end
        end
        ST_DONE: begin
          w_nxt = ST_IDLE;
        end
        default: begin
          w_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Moore outputs registered from the next state so they change exactly with the state.
  always_ff @(posedge i_clk_blf or posedge i_rst_for_new_package) begin
    if (i_rst_for_new_package) begin
      r_m_q           <= M_FM0;
      r_trext_q       <= 1'b0;
      r_start_working <= 1'b0;
      r_en_frm_clk    <= 1'b0;
      r_en_fm0_clk    <= 1'b0;
      r_en_mil_clk    <= 1'b0;
      r_tx_busy       <= 1'b0;
      r_tx_done       <= 1'b0;
      r_tx_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_m_q     <= i_m;
        r_trext_q <= i_trext;
      end
      // m_q is already stable here: accept only ever leads to WAIT_T1 (enables off).
      r_start_working <= w_nxt_active;
      r_en_frm_clk    <= w_nxt_active;
      r_en_fm0_clk    <= w_nxt_active && (r_m_q == M_FM0);
      r_en_mil_clk    <= w_nxt_active && (r_m_q != M_FM0);
      r_tx_busy       <= (w_nxt != ST_IDLE);
      r_tx_done       <= (w_nxt == ST_DONE);
      if (w_accept) begin
        r_tx_err <= 1'b0;
      end else if (w_err_set) begin
        r_tx_err <= 1'b1;
      end
    end
  end

  assign o_start_working = r_start_working;
  assign o_en_frm_clk    = r_en_frm_clk;
  assign o_en_fm0_clk    = r_en_fm0_clk;
  assign o_en_mil_clk    = r_en_mil_clk;
  assign o_tx_busy       = r_tx_busy;
  assign o_tx_done       = r_tx_done;
  assign o_tx_err        = r_tx_err;
  assign o_trext_q       = r_trext_q;

endmodule

// File: tb/tb_tx_sched.sv
// Bench for tx_sched: table-driven transactions with a per-cycle timeline check and an outcome scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_tx_sched;

  localparam int T1 = 4;
  localparam int WD = 20;

  logic       clk;
  logic       rst;
  logic       reply_req;
  logic       abort;
  logic [1:0] m;
  logic       trext;
  logic       p_complete;
  logic       bs_complete;
  logic       start_working;
  logic       en_frm_clk;
  logic       en_fm0_clk;
  logic       en_mil_clk;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  logic       trext_q;

  tx_sched #(
    .T1_CYC   (T1),
    .WDOG_W   (16),
    .WDOG_MAX (WD)
  ) dut (
    .i_clk_blf             (clk),
    .i_rst_for_new_package (rst),
    .i_reply_req           (reply_req),
    .i_abort               (abort),
    .i_m                   (m),
    .i_trext               (trext),
    .i_p_complete          (p_complete),
    .i_bs_complete         (bs_complete),
    .o_start_working       (start_working),
    .o_en_frm_clk          (en_frm_clk),
    .o_en_fm0_clk          (en_fm0_clk),
    .o_en_mil_clk          (en_mil_clk),
    .o_tx_busy             (tx_busy),
    .o_tx_done             (tx_done),
    .o_tx_err              (tx_err),
    .o_trext_q             (trext_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge offsets are counted from the edge that samples the accepted reply_req (offset 0).
  // Inputs at offset k are sampled by edge k; outputs at offset k are read just after edge k.
  typedef struct {
    logic [1:0] m;
    logic       trext;
    int         p_at;
    int         bs_at;
    int         ab_at;
    int         rq2_at;
    int         act_end;  // edge at which start_working/enables drop
    int         idle_at;  // edge at which tx_busy drops
    int         done_at;  // edge after which tx_done is high, -1 for none
    logic       fin_err;  // tx_err after the transaction ends
  } vec_t;

  typedef struct {
    int   done_cnt;
    logic err;
  } sb_t;

  localparam int NV = 11;
  vec_t vecs [NV];
  sb_t  sbq [$];

  int   checks   = 0;
  int   failures = 0;
  int   done_seen = 0;
  logic prev_busy = 1'b0;

  task automatic chk(input string nm, input int idx, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d cyc=%0d got=%0h want=%0h", nm, idx, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_start"}, -1, 0, {31'd0, start_working}, 32'd0);
    chk({nm, "_frm"},   -1, 0, {31'd0, en_frm_clk},    32'd0);
    chk({nm, "_fm0"},   -1, 0, {31'd0, en_fm0_clk},    32'd0);
    chk({nm, "_mil"},   -1, 0, {31'd0, en_mil_clk},    32'd0);
    chk({nm, "_busy"},  -1, 0, {31'd0, tx_busy},       32'd0);
    chk({nm, "_done"},  -1, 0, {31'd0, tx_done},       32'd0);
    chk({nm, "_err"},   -1, 0, {31'd0, tx_err},        32'd0);
    chk({nm, "_trext"}, -1, 0, {31'd0, trext_q},       32'd0);
  endtask

  // Observe transaction ends and settle them against the scoreboard.
  task automatic monitor(input int idx, input int k);
    sb_t e;
    if (tx_done) done_seen++;
    if (prev_busy && !tx_busy) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", idx, k, 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_done_cnt", idx, k, 32'(done_seen), 32'(e.done_cnt));
        chk("sb_err", idx, k, {31'd0, tx_err}, {31'd0, e.err});
      end
      done_seen = 0;
    end
    prev_busy = tx_busy;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    sb_t  e;
    logic e_start;
    logic e_err;
    v = vecs[idx];
    done_seen = 0;
    for (int k = 0; k <= v.idle_at + 2; k++) begin
      reply_req   = (k == 0) || (k == v.rq2_at);
      abort       = (k == v.ab_at);
      p_complete  = (k == v.p_at);
      bs_complete = (k == v.bs_at);
      m           = (k == 0) ? v.m : ~v.m;
      trext       = (k == 0) ? v.trext : ~v.trext;
      if (k == 0) begin
        e.done_cnt = (v.done_at >= 0) ? 1 : 0;
        e.err      = v.fin_err;
        sbq.push_back(e);
      end
      step();
      e_start = (k >= T1) && (k < v.act_end);
      e_err   = (k >= v.idle_at) ? v.fin_err : 1'b0;
      chk("start", idx, k, {31'd0, start_working}, {31'd0, e_start});
      chk("frm",   idx, k, {31'd0, en_frm_clk},    {31'd0, e_start});
      chk("fm0",   idx, k, {31'd0, en_fm0_clk},    {31'd0, e_start && (v.m == 2'd0)});
      chk("mil",   idx, k, {31'd0, en_mil_clk},    {31'd0, e_start && (v.m != 2'd0)});
      chk("busy",  idx, k, {31'd0, tx_busy},       {31'd0, k < v.idle_at});
      chk("done",  idx, k, {31'd0, tx_done},       {31'd0, k == v.done_at});
      chk("err",   idx, k, {31'd0, tx_err},        {31'd0, e_err});
      chk("trext", idx, k, {31'd0, trext_q},       {31'd0, v.trext});
      monitor(idx, k);
    end
    reply_req = 1'b0; abort = 1'b0; p_complete = 1'b0; bs_complete = 1'b0;
    if (sbq.size() != 0) begin
      chk("sb_timeout", idx, -1, 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  initial begin
    //          m     trext p_at bs_at ab_at rq2  act  idle done err
    vecs[0]  = '{2'd0, 1'b0, 10,  20,   -1,   -1,  20,  21,  20,  1'b0}; // FM0 normal
    vecs[1]  = '{2'd2, 1'b1, 10,  20,   -1,   12,  20,  21,  20,  1'b0}; // Miller, req in PAYLOAD
    vecs[2]  = '{2'd1, 1'b0,  6,  15,   -1,    2,  15,  16,  15,  1'b0}; // req in WAIT_T1
    vecs[3]  = '{2'd3, 1'b1,  9,   9,   -1,   -1,   9,  10,   9,  1'b0}; // p and bs together
    vecs[4]  = '{2'd0, 1'b0, -1,   8,   -1,   -1,   8,   9,   8,  1'b0}; // bs in PREAMBLE
    vecs[5]  = '{2'd0, 1'b1,  8,  -1,   -1,   -1,  24,  24,  -1,  1'b1}; // watchdog expiry
    vecs[6]  = '{2'd1, 1'b0,  8,  -1,   11,   -1,  11,  11,  -1,  1'b0}; // abort 3 into PAYLOAD, clears err
    vecs[7]  = '{2'd0, 1'b1, -1,  24,   -1,   -1,  24,  25,  24,  1'b0}; // bs on expiry cycle
    vecs[8]  = '{2'd2, 1'b0, -1,   7,    7,   -1,   7,   7,  -1,  1'b0}; // abort beats bs
    vecs[9]  = '{2'd0, 1'b1, -1,  -1,    2,   -1,   2,   2,  -1,  1'b0}; // abort in WAIT_T1
    vecs[10] = '{2'd3, 1'b0, -1,  -1,   24,   -1,  24,  24,  -1,  1'b0}; // abort beats expiry

    rst = 1'b1; reply_req = 1'b0; abort = 1'b0; m = 2'd0; trext = 1'b0;
    p_complete = 1'b0; bs_complete = 1'b0;
    #12;
    chk_all_zero("reset");
    #10;
    rst = 1'b0;
    step();
    step();
    chk_all_zero("post_reset");

    for (int i = 0; i <= 5; i++) run_vec(i);

    // After watchdog: reply_req together with abort must not be accepted; err stays set.
    reply_req = 1'b1; abort = 1'b1; m = 2'd1; trext = 1'b0;
    step();
    chk("req_abort_busy", -1, 0, {31'd0, tx_busy}, 32'd0);
    chk("req_abort_err",  -1, 0, {31'd0, tx_err},  32'd1);
    reply_req = 1'b0;
    step();
    chk("abort_idle_busy", -1, 1, {31'd0, tx_busy}, 32'd0);
    chk("abort_idle_err",  -1, 1, {31'd0, tx_err},  32'd1);
    chk("abort_idle_trext", -1, 1, {31'd0, trext_q}, 32'd1);
    abort = 1'b0;
    step();
    prev_busy = tx_busy;

    for (int i = 6; i < NV; i++) run_vec(i);

    // Async reset mid-PAYLOAD, asserted between edges.
    reply_req = 1'b1; m = 2'd2; trext = 1'b1;
    step();
    reply_req = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      p_complete = (k == 6);
      step();
    end
    p_complete = 1'b0;
    chk("pre_rst_start", -1, 9, {31'd0, start_working}, 32'd1);
    chk("pre_rst_mil",   -1, 9, {31'd0, en_mil_clk},    32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    step();
    #3;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rel_busy",  -1, k, {31'd0, tx_busy},       32'd0);
      chk("rel_done",  -1, k, {31'd0, tx_done},       32'd0);
      chk("rel_start", -1, k, {31'd0, start_working}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
